// File: rtl/encrypter_packetizer_if.sv
// Handshake bundle between the plaintext source, the encrypter and the
// downstream decrypter: input word channel, packet channel and counter.
interface encrypter_packetizer_if;
    logic        in_valid;
    logic        in_ready;
    logic [59:0] plain_in;
    logic        out_valid;
    logic        out_ready;
    logic [77:0] data_encrypted;
    logic [15:0] pkt_count;

    modport master (
        output in_valid,
        output plain_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  data_encrypted,
        input  pkt_count
    );

    modport slave (
        input  in_valid,
        input  plain_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output data_encrypted,
        output pkt_count
    );
endinterface

// File: rtl/encrypter_packetizer.sv
// Encrypts 60-bit words with an LFSR-chosen function/key into 78-bit packets.
// Ports: Clk, Rst (sync, active-high), bus (slave: in/out handshakes,
// data_encrypted = {body, key, sel}, pkt_count).
module encrypter_packetizer #(
    parameter logic [17:0] SEED = 18'h00001
) (
    input  logic Clk,
    input  logic Rst,
    encrypter_packetizer_if.slave bus
);

    // An all-zero LFSR would lock up, so fall back to 1.
    localparam logic [17:0] SEED_EFF = (SEED == 18'd0) ? 18'h00001 : SEED;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    state_t      state;
    logic [17:0] lfsr;
    logic [59:0] plain_q;
    logic [11:0] key_q;
    logic [5:0]  sel_q;
    logic [77:0] pkt_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic [15:0] cnt_q;
    logic [15:0] cnt_nxt;
    logic [59:0] k60;
    logic [59:0] body;
    logic        deliver;

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.data_encrypted = pkt_q;
    assign bus.pkt_count      = cnt_q;

    assign deliver = out_valid_q && bus.out_ready;

    always_comb begin
        k60  = {5{key_q}};
        body = '0;
        unique case (1'b1)
            (sel_q[5:4] == 2'd0): body = plain_q ^ k60;
            (sel_q[5:4] == 2'd1): body = {plain_q[47:0], plain_q[59:48]} ^ k60;
            (sel_q[5:4] == 2'd2): body = {plain_q[29:0], plain_q[59:30]} ^ k60;
            default: begin
                // Per-lane add; the carry out of each 12-bit lane is dropped.
                for (int i = 0; i < 5; i++) begin
                    body[i*12 +: 12] = plain_q[i*12 +: 12] + key_q;
                end
            end
        endcase
    end

    // Next count is recomputed from the current count every cycle.
    always_comb begin
        cnt_nxt = cnt_q;
        if (deliver) begin
            cnt_nxt = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= IDLE;
            lfsr        <= SEED_EFF;
            plain_q     <= '0;
            key_q       <= '0;
            sel_q       <= '0;
            pkt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_ready_q && bus.in_valid) begin
                        plain_q    <= bus.plain_in;
                        sel_q      <= lfsr[5:0];
                        key_q      <= lfsr[17:6];
                        lfsr       <= {lfsr[16:0], lfsr[17] ^ lfsr[10]};
                        in_ready_q <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    pkt_q       <= {body, key_q, sel_q};
                    out_valid_q <= 1'b1;
                    state       <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_encrypter_packetizer.sv
// Directed bench for encrypter_packetizer: five seeds driven in lockstep,
// checking packets, latency, backpressure, reset recovery and count wrap.
module tb_encrypter_packetizer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        in_valid;
    logic [59:0] plain_in;
    logic        out_ready;
    int          n_cmp = 0;
    int          n_bad = 0;

    localparam logic [59:0] P  = 60'h123456789ABCDEF;
    localparam logic [59:0] PR = 60'h456789ABCDEF123;
    localparam logic [59:0] F1 = 60'hFFFFFFFFFFFFFFF;

    always #5 Clk = ~Clk;

    encrypter_packetizer_if b0 ();
    encrypter_packetizer_if b1 ();
    encrypter_packetizer_if b2 ();
    encrypter_packetizer_if b3 ();
    encrypter_packetizer_if b4 ();

    assign b0.in_valid  = in_valid;
    assign b0.plain_in  = plain_in;
    assign b0.out_ready = out_ready;
    assign b1.in_valid  = in_valid;
    assign b1.plain_in  = plain_in;
    assign b1.out_ready = out_ready;
    assign b2.in_valid  = in_valid;
    assign b2.plain_in  = plain_in;
    assign b2.out_ready = out_ready;
    assign b3.in_valid  = in_valid;
    assign b3.plain_in  = plain_in;
    assign b3.out_ready = out_ready;
    assign b4.in_valid  = in_valid;
    assign b4.plain_in  = plain_in;
    assign b4.out_ready = out_ready;

    encrypter_packetizer #(.SEED(18'h00001)) dut0 (.Clk(Clk), .Rst(Rst), .bus(b0));
    encrypter_packetizer #(.SEED(18'h00010)) dut1 (.Clk(Clk), .Rst(Rst), .bus(b1));
    encrypter_packetizer #(.SEED(18'h3FFE0)) dut2 (.Clk(Clk), .Rst(Rst), .bus(b2));
    encrypter_packetizer #(.SEED(18'h00070)) dut3 (.Clk(Clk), .Rst(Rst), .bus(b3));
    encrypter_packetizer #(.SEED(18'h00000)) dut4 (.Clk(Clk), .Rst(Rst), .bus(b4));

    task automatic check(input string tag, input logic [77:0] got,
                         input logic [77:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        plain_in  = '0;
        tick;
        tick;
        check("rst_in_ready", 78'(b0.in_ready), 78'd0);
        check("rst_out_valid", 78'(b0.out_valid), 78'd0);
        check("rst_data", b0.data_encrypted, 78'd0);
        check("rst_count", 78'(b0.pkt_count), 78'd0);
        Rst = 1'b0;
        tick;
        check("post_rst_ready", 78'(b0.in_ready), 78'd1);
    endtask

    task automatic send(input logic [59:0] w);
        int n;
        n = 0;
        while (!b0.in_ready && n < 8) begin
            tick;
            n++;
        end
        check("send_ready", 78'(b0.in_ready), 78'd1);
        in_valid = 1'b1;
        plain_in = w;
        tick;
        in_valid = 1'b0;
        check("calc_valid", 78'(b0.out_valid), 78'd0);
        tick;
        check("latency_valid", 78'(b0.out_valid), 78'd1);
    endtask

    task automatic deliver;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("dlv_in_ready", 78'(b0.in_ready), 78'd1);
        check("dlv_out_valid", 78'(b0.out_valid), 78'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset;

        send(P);
        check("f1_pkt", b0.data_encrypted, {P, 12'h000, 6'd1});
        check("f2_pkt", b1.data_encrypted, {PR, 12'h000, 6'd16});
        check("seed0_pkt", b4.data_encrypted, {P, 12'h000, 6'd1});
        deliver;
        check("f1_count", 78'(b0.pkt_count), 78'd1);

        send(P);
        check("lfsr_adv", b0.data_encrypted, {P, 12'h000, 6'd2});
        deliver;
        check("count2", 78'(b0.pkt_count), 78'd2);

        do_reset;
        send(60'd0);
        check("f3_pkt", b2.data_encrypted, {F1, 12'hFFF, 6'd32});
        check("f4_pkt", b3.data_encrypted,
              {60'h001001001001001, 12'h001, 6'd48});
        deliver;

        do_reset;
        send(F1);
        check("f4_wrap", b3.data_encrypted, {60'd0, 12'h001, 6'd48});
        deliver;

        do_reset;
        send(P);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            plain_in = {28'd0, 32'($urandom)};
            tick;
            check("bp_data", b0.data_encrypted, {P, 12'h000, 6'd1});
            check("bp_in_ready", 78'(b0.in_ready), 78'd0);
            check("bp_out_valid", 78'(b0.out_valid), 78'd1);
            check("bp_count", 78'(b0.pkt_count), 78'd0);
        end
        in_valid = 1'b0;
        deliver;
        check("bp_count_dlv", 78'(b0.pkt_count), 78'd1);
        send(P);
        check("bp_no_adv", b0.data_encrypted, {P, 12'h000, 6'd2});
        deliver;

        in_valid = 1'b1;
        plain_in = P;
        tick;
        in_valid = 1'b0;
        Rst = 1'b1;
        tick;
        Rst = 1'b0;
        check("rcalc_valid", 78'(b0.out_valid), 78'd0);
        check("rcalc_count", 78'(b0.pkt_count), 78'd0);
        check("rcalc_ready", 78'(b0.in_ready), 78'd0);
        send(P);
        check("rcalc_seed", b0.data_encrypted, {P, 12'h000, 6'd1});
        Rst = 1'b1;
        tick;
        Rst = 1'b0;
        check("rout_valid", 78'(b0.out_valid), 78'd0);
        check("rout_data", b0.data_encrypted, 78'd0);
        send(F1);
        check("rout_seed", b0.data_encrypted, {F1, 12'h000, 6'd1});

        force dut0.cnt_q = 16'hFFFF;
        tick;
        release dut0.cnt_q;
        tick;
        check("wrap_pre", 78'(b0.pkt_count), 78'hFFFF);
        deliver;
        check("wrap", 78'(b0.pkt_count), 78'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
